slip_unescape: RTL
==================

# slip_unescape

Upstream neighbour of `gearbox_packing` in the byte-stream receive path. Accepts n-byte AXI-Stream words and decodes SLIP (RFC 1055) byte-stuffing:

- Frame delimiters and escape bytes are dropped.
- Escaped bytes are restored in place.
- Each dropped byte is marked by clearing its `tkeep` bit, leaving `gearbox_packing` to compact the sparse words.

Escape sequences may span beat boundaries. The block adds one register stage with full-throughput backpressure.

## Interface
- `n`, 5, bytes per beat
- `nb`, n*8, data width in bits
- `END_B`, 8'hC0, frame delimiter; always dropped
- `ESC_B`, 8'hDB, escape byte; always dropped
- `ESC_END`, 8'hDC, after ESC decodes to END_B
- `ESC_ESC`, 8'hDD, after ESC decodes to ESC_B
- `aclk`  in  1  clock; all logic on rising edge
- `aresetn`  in  1  reset; asynchronous, active-low
- `in_tdata`  in  nb  input bytes; byte n-1 (`[nb-1:nb-8]`) is first in stream order
- `in_tkeep`  in  n  input byte enables; 0 = byte absent
- `in_tvalid`  in  1  input valid
- `in_tready`  out  1  input ready; registered
- `out_tdata`  out  nb  decoded bytes; dropped positions forced to 8'h00
- `out_tkeep`  out  n  1 = byte carries a decoded payload byte
- `out_tvalid`  out  1  output valid
- `out_tready`  in  1  output ready
- `err_cnt`  out  16  saturating count of invalid escapes

## Operation
- Beats are decoded only on input handshake (`in_tvalid & in_tready`). Bytes are scanned from index n-1 down to 0.
- Bytes with `in_tkeep=0` stay `keep=0` and data 0; they do not touch escape state.
- Decode rules, with state flag `esc_pend`:
  - `esc_pend=0`, byte `END_B`: drop.
  - `esc_pend=0`, byte `ESC_B`: drop, set `esc_pend`.
  - `esc_pend=0`, any other byte: pass unchanged.
  - `esc_pend=1`, byte `ESC_END`: emit `END_B`.
  - `esc_pend=1`, byte `ESC_ESC`: emit `ESC_B`.
  - `esc_pend=1`, any other byte: emit the byte unchanged, `err_cnt++`, and clear `esc_pend`.
  - `esc_pend=1`, byte `ESC_B`: treat as invalid; the byte is emitted as 8'hDB and `esc_pend` clears.
- `esc_pend` carries across beats. It updates only on accepted beats and never on stalled beats.
- Beats whose decoded keep is all-zero are still emitted with `out_tkeep=0`. `gearbox_packing` ignores them.
- `err_cnt` saturates at 16'hFFFF. With several invalid escapes in one beat it adds their count, saturating.
- `out_tkeep` bits never set where `in_tkeep` was 0.

## Timing
- Latency: an accepted beat appears on `out_*` on the next clock edge when the output register is empty or draining.
- Throughput: 1 beat/cycle while `out_tready=1`.
- Skid buffer, 2 entries: `in_tready` is registered.
  - It deasserts the cycle after the skid entry fills.
  - It reasserts the cycle after the skid entry drains.
- No beat is lost or duplicated; order is preserved.
- AXI rules:
  - `out_tvalid`, once high, stays high with `out_tdata`/`out_tkeep` stable until `out_tready`.
  - `in_tdata`/`in_tkeep` are sampled only at handshake.
- Reset (asynchronous assert, release synchronised externally):
  - `out_tvalid=0`, `out_tdata=0`, `out_tkeep=0`, `in_tready=0`, `err_cnt=0`, `esc_pend=0`, skid empty.
  - `in_tready` rises on the first edge after release.
- Reset mid-operation discards the skid and output contents and any pending escape.

## Structure
- Package `slip_pkg`:
  - constants `END_B`, `ESC_B`, `ESC_END`, `ESC_ESC`;
  - a pure function `slip_decode_beat(data, keep, esc_in)` returning data, keep, esc_out and err count.
- Sub-module `axis_skid_buffer` (parameter width = nb+n) provides the registered-ready 2-entry stage. Decode sits combinationally in front of it.
- The top holds `esc_pend`, the `err_cnt` register and the decode instance.

## Test plan
- Plain data, n=5: `11_22_33_44_55` keep `1F` → next cycle out `11_22_33_44_55` keep `1F`, `err_cnt=0`.
- In-beat escape: `11_DB_DC_22_33` keep `1F` → out `11_00_C0_22_33` keep `17`.
- Cross-beat escape:
  - Beat 1 `11_22_33_44_DB` → out `11_22_33_44_00` keep `1E`.
  - Beat 2 `DD_55_66_77_88` → out `DB_55_66_77_88` keep `1F`.
- Drop and error: `C0_DB_41_42_43` → out `00_00_41_42_43` keep `07`, `err_cnt=1`. Separately, preload `err_cnt=FFFF` → stays `FFFF`.
- Backpressure:
  - Stimulus: 6 back-to-back beats with an escape crossing beats 2→3; `out_tready=0` for 3 cycles.
  - Response: `in_tready` falls after 2 buffered beats; all 6 outputs correct, in order; stalled beats do not advance `esc_pend`.
- Reset mid-stream:
  - Stimulus: accept `11_22_33_44_DB`, assert `aresetn=0` asynchronously, release, send `DC_01_02_03_04`.
  - Response: outputs 0 during reset; post-reset out `DC_01_02_03_04` keep `1F`, i.e. no pending escape.

Source files
------------

// File: rtl/slip_pkg.sv
// Shared constants and the per-beat SLIP decode function for the receive path.
// The decode is pure so the top can drive it from the current escape state.
package slip_pkg;

    localparam int N     = 5;
    localparam int NB    = N * 8;
    localparam int ERR_W = $clog2(N + 1);

    localparam logic [7:0] END_B   = 8'hC0;
    localparam logic [7:0] ESC_B   = 8'hDB;
    localparam logic [7:0] ESC_END = 8'hDC;
    localparam logic [7:0] ESC_ESC = 8'hDD;

    typedef struct packed {
        logic [NB-1:0]    data;
        logic [N-1:0]     keep;
        logic             esc_out;
        logic [ERR_W-1:0] err;
    } decode_t;

    // Byte N-1 is first in stream order, so the escape flag ripples from the top byte down.
    function automatic decode_t slip_decode_beat(input logic [NB-1:0] data,
                                                 input logic [N-1:0]  keep,
                                                 input logic          esc_in);
        decode_t    r;
        logic       esc;
        logic [7:0] b;
        r   = '0;
        esc = esc_in;
        for (int i = N - 1; i >= 0; i--) begin
            b = data[i*8 +: 8];
            if (keep[i]) begin
                if (!esc) begin
                    if (b == ESC_B) begin
                        esc = 1'b1;
                    end else if (b != END_B) begin
                        r.data[i*8 +: 8] = b;
                        r.keep[i]        = 1'b1;
                    end
                end else begin
                    esc       = 1'b0;
                    r.keep[i] = 1'b1;
                    case (b)
                        ESC_END: r.data[i*8 +: 8] = END_B;
                        ESC_ESC: r.data[i*8 +: 8] = ESC_B;
                        default: begin
                            r.data[i*8 +: 8] = b;
                            r.err            = r.err + ERR_W'(1);
                        end
                    endcase
                end
            end
        end
        r.esc_out = esc;
        return r;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register stage with a registered ready: an output register
// plus one skid entry that catches the beat accepted while ready was still high.
module axis_skid_buffer #(
    parameter int width = 8
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [width-1:0] skid_data;
    logic             skid_valid;
    logic             in_fire;
    logic             load_out;
    logic             skid_fill;
    logic             skid_valid_next;

    assign in_fire   = in_valid & in_ready;
    assign load_out  = out_ready | ~out_valid;
    assign skid_fill = in_fire & ~load_out;

    always_comb begin
        skid_valid_next = skid_valid;
        if (skid_valid) begin
            skid_valid_next = ~load_out;
        end else begin
            skid_valid_next = skid_fill;
        end
    end

    // Ready simply mirrors "skid will be empty", so it is known one cycle ahead.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            in_ready   <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            in_ready   <= ~skid_valid_next;
            skid_valid <= skid_valid_next;
            if (skid_fill) begin
                skid_data <= in_data;
            end
            if (load_out) begin
                if (skid_valid) begin
                    out_data  <= skid_data;
                    out_valid <= 1'b1;
                end else if (in_fire) begin
                    out_data  <= in_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/slip_unescape.sv
// SLIP unescaper: decodes accepted beats in place, marks dropped bytes via tkeep,
// and registers the result through a skid stage.
module slip_unescape
    import slip_pkg::*;
(
    input  logic          aclk,
    input  logic          aresetn,
    input  logic [NB-1:0] in_tdata,
    input  logic [N-1:0]  in_tkeep,
    input  logic          in_tvalid,
    output logic          in_tready,
    output logic [NB-1:0] out_tdata,
    output logic [N-1:0]  out_tkeep,
    output logic          out_tvalid,
    input  logic          out_tready,
    output logic [15:0]   err_cnt
);

    logic            esc_pend;
    decode_t         dec;
    logic            in_fire;
    logic [16:0]     err_sum;
    logic [NB+N-1:0] skid_out;

    assign dec     = slip_decode_beat(in_tdata, in_tkeep, esc_pend);
    assign in_fire = in_tvalid & in_tready;
    assign err_sum = {1'b0, err_cnt} + 17'(dec.err);

    // Escape state and error count only move on accepted beats.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            esc_pend <= 1'b0;
            err_cnt  <= '0;
        end else if (in_fire) begin
            esc_pend <= dec.esc_out;
            err_cnt  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    axis_skid_buffer #(
        .width (NB + N)
    ) u_skid (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   ({dec.data, dec.keep}),
        .in_valid  (in_tvalid),
        .in_ready  (in_tready),
        .out_data  (skid_out),
        .out_valid (out_tvalid),
        .out_ready (out_tready)
    );

    assign out_tdata = skid_out[NB+N-1:N];
    assign out_tkeep = skid_out[N-1:0];

endmodule
